apb_cipher_slave: RTL and testbench



---
 rtl/apb_cipher_slave.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_apb_cipher_slave.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cipher_slave.sv
// rtl/apb_cipher_slave.sv - APB register front-end for an iterative block cipher with TX/RX FIFOs
//
// Purpose:
//   Software loads KEY and CTRL, pushes 32-bit words through DIN into a TX
//   FIFO, a one-word-at-a-time round engine transforms each word, and the
//   results are popped from an RX FIFO through DOUT. DIN writes stall while
//   the TX FIFO is full and the engine is enabled. DOUT reads stall while a
//   result is still on its way.
//
// Ports:
//   clk      in   1  clock
//   rst      in   1  asynchronous active-high reset
//   psel     in   1  APB select
//   penable  in   1  APB access phase
//   pwrite   in   1  1 = write, 0 = read
//   paddr    in  32  address, only paddr[4:2] decoded
//   pwdata   in  32  write data
//   prdata   out 32  read data, combinational, 0 outside a read access
//   pready   out  1  transfer complete, combinational

module apb_cipher_slave #(
    parameter int DEPTH  = 4,
    parameter int ROUNDS = 4,
    parameter int ROT    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(ROUNDS + 1);

    localparam logic [2:0]    ADDR_CTRL  = 3'd0;
    localparam logic [2:0]    ADDR_STAT  = 3'd1;
    localparam logic [2:0]    ADDR_KEY   = 3'd2;
    localparam logic [2:0]    ADDR_DIN   = 3'd3;
    localparam logic [2:0]    ADDR_DOUT  = 3'd4;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_RUN  = 2'd1,
        ENG_DONE = 2'd2
    } eng_state_t;

    // Software-visible registers; ctrl [0] = enable, [1] = mode (1 = decrypt)
    logic [1:0]    ctrl_q, ctrl_d;
    logic [31:0]   key_q, key_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    // Engine state, with its own copy of key/mode taken when a word is popped
    eng_state_t    state_q, state_d;
    logic [31:0]   data_q, data_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [31:0]   ekey_q, ekey_d;
    logic          emode_q, emode_d;

    logic [31:0]   tx_mem_q [DEPTH];
    logic [31:0]   tx_mem_d [DEPTH];
    logic [PW-1:0] tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;

    logic [31:0]   rx_mem_q [DEPTH];
    logic [31:0]   rx_mem_d [DEPTH];
    logic [PW-1:0] rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;

    logic [2:0]    reg_sel;
    logic          paddr_unused;
    logic          access, commit, wr_commit, rd_commit;
    logic          enable, busy, pending;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic          apb_push, apb_pop, eng_pop, eng_push;
    logic          ctrl_wr, key_wr, fifo_clr, flag_clr, ovf_set, udf_set;
    logic [31:0]   stat;

    function automatic logic [31:0] rotl(input logic [31:0] x);
        return (x << ROT) | (x >> (32 - ROT));
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x);
        return (x >> ROT) | (x << (32 - ROT));
    endfunction

    assign reg_sel      = paddr[4:2];
    assign paddr_unused = ^{paddr[31:5], paddr[1:0]};

    assign enable   = ctrl_q[0];
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == FULL_CNT);
    assign rx_empty = (rx_cnt_q == '0);
    assign busy     = (state_q != ENG_IDLE);
    // A result is still coming if the engine holds a word or TX has one queued
    assign pending  = busy | ~tx_empty;

    assign access    = psel & penable;
    assign commit    = access & pready;
    assign wr_commit = commit & pwrite;
    assign rd_commit = commit & ~pwrite;

    assign ctrl_wr  = wr_commit & (reg_sel == ADDR_CTRL);
    assign key_wr   = wr_commit & (reg_sel == ADDR_KEY);
    assign fifo_clr = ctrl_wr & pwdata[2];
    assign flag_clr = ctrl_wr & pwdata[3];

    // A full-FIFO DIN write can only commit while disabled (otherwise it
    // stalls), so a committed write into a full FIFO is a drop.
    assign apb_push = wr_commit & (reg_sel == ADDR_DIN) & ~tx_full;
    assign ovf_set  = wr_commit & (reg_sel == ADDR_DIN) & tx_full;
    assign apb_pop  = rd_commit & (reg_sel == ADDR_DOUT) & ~rx_empty;
    assign udf_set  = rd_commit & (reg_sel == ADDR_DOUT) & rx_empty;

    always_comb begin
        stat        = '0;
        stat[0]     = tx_full;
        stat[1]     = tx_empty;
        stat[2]     = rx_full;
        stat[3]     = rx_empty;
        stat[4]     = busy;
        stat[5]     = ovf_q;
        stat[6]     = udf_q;
        stat[11:8]  = 4'(tx_cnt_q);
        stat[19:16] = 4'(rx_cnt_q);
    end

    // APB response: wait states only for DIN into a full FIFO while enabled,
    // and for DOUT from an empty FIFO while a result is still on its way.
    always_comb begin
        pready = 1'b1;
        prdata = '0;
        if (access) begin
            if (pwrite) begin
                if ((reg_sel == ADDR_DIN) && tx_full && enable) begin
                    pready = 1'b0;
                end
            end else begin
                case (reg_sel)
                    ADDR_CTRL: prdata = {30'd0, ctrl_q};
                    ADDR_STAT: prdata = stat;
                    ADDR_KEY:  prdata = key_q;
                    ADDR_DOUT: begin
                        if (!rx_empty) begin
                            prdata = rx_mem_q[rx_rd_q];
                        end else if (pending && enable) begin
                            pready = 1'b0;
                        end
                    end
                    default: prdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        ctrl_d = ctrl_wr ? pwdata[1:0] : ctrl_q;
        key_d  = key_wr ? pwdata : key_q;
        // A set in the same cycle as a clear wins
        ovf_d  = (ovf_q & ~flag_clr) | ovf_set;
        udf_d  = (udf_q & ~flag_clr) | udf_set;
    end

    // Engine: IDLE pops a word, RUN applies one round per clock, DONE waits
    // for room in RX. fifo_clr abandons the word in flight.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        ekey_d   = ekey_q;
        emode_d  = emode_q;
        eng_pop  = 1'b0;
        eng_push = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (enable && !tx_empty) begin
                    eng_pop = 1'b1;
                    data_d  = tx_mem_q[tx_rd_q];
                    ekey_d  = key_q;
                    emode_d = ctrl_q[1];
                    cnt_d   = '0;
                    state_d = ENG_RUN;
                end
            end
            ENG_RUN: begin
                data_d = emode_q ? (rotr(data_q) ^ ekey_q) : rotl(data_q ^ ekey_q);
                cnt_d  = cnt_q + RW'(1);
                if (cnt_q == LAST_ROUND) begin
                    state_d = ENG_DONE;
                end
            end
            ENG_DONE: begin
                if (!rx_full) begin
                    eng_push = 1'b1;
                    state_d  = ENG_IDLE;
                end
            end
            default: state_d = ENG_IDLE;
        endcase
        if (fifo_clr) begin
            state_d  = ENG_IDLE;
            eng_pop  = 1'b0;
            eng_push = 1'b0;
        end
    end

    always_comb begin
        tx_mem_d = tx_mem_q;
        tx_wr_d  = tx_wr_q;
        tx_rd_d  = tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (fifo_clr) begin
            tx_wr_d  = '0;
            tx_rd_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (apb_push) begin
                tx_mem_d[tx_wr_q] = pwdata;
                tx_wr_d           = tx_wr_q + PW'(1);
            end
            if (eng_pop) begin
                tx_rd_d = tx_rd_q + PW'(1);
            end
            tx_cnt_d = tx_cnt_q + CW'(apb_push) - CW'(eng_pop);
        end
    end

    always_comb begin
        rx_mem_d = rx_mem_q;
        rx_wr_d  = rx_wr_q;
        rx_rd_d  = rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (fifo_clr) begin
            rx_wr_d  = '0;
            rx_rd_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (eng_push) begin
                rx_mem_d[rx_wr_q] = data_q;
                rx_wr_d           = rx_wr_q + PW'(1);
            end
            if (apb_pop) begin
                rx_rd_d = rx_rd_q + PW'(1);
            end
            rx_cnt_d = rx_cnt_q + CW'(eng_push) - CW'(apb_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            key_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            state_q  <= ENG_IDLE;
            data_q   <= '0;
            cnt_q    <= '0;
            ekey_q   <= '0;
            emode_q  <= 1'b0;
            tx_mem_q <= '{default: '0};
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            tx_cnt_q <= '0;
            rx_mem_q <= '{default: '0};
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            key_q    <= key_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            ekey_q   <= ekey_d;
            emode_q  <= emode_d;
            tx_mem_q <= tx_mem_d;
            tx_rd_q  <= tx_rd_d;
            tx_wr_q  <= tx_wr_d;
            tx_cnt_q <= tx_cnt_d;
            rx_mem_q <= rx_mem_d;
            rx_rd_q  <= rx_rd_d;
            rx_wr_q  <= rx_wr_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

endmodule

// File: tb/tb_apb_cipher_slave.sv
// tb/tb_apb_cipher_slave.sv - self-checking bench for apb_cipher_slave

module tb_apb_cipher_slave;

    localparam int DEPTH  = 4;
    localparam int ROUNDS = 4;
    localparam int ROT    = 3;

    localparam logic [31:0] A_CTRL = 32'h00;
    localparam logic [31:0] A_STAT = 32'h04;
    localparam logic [31:0] A_KEY  = 32'h08;
    localparam logic [31:0] A_DIN  = 32'h0C;
    localparam logic [31:0] A_DOUT = 32'h10;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [31:0] ctrl;
        logic [31:0] key;
        logic [31:0] din;
        logic [31:0] exp;
    } cipher_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_cipher_slave #(.DEPTH(DEPTH), .ROUNDS(ROUNDS), .ROT(ROT)) dut (
        .clk     (clk),
        .rst     (rst),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts its setup phase immediately; call just after a rising edge.
    // Returns 1 time unit after the commit edge with the bus idle.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int waits);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        @(posedge clk);
        #1;
        penable = 1'b1;
        waits   = 0;
        rdata   = '0;
        forever begin
            @(negedge clk);
            if (pready) begin
                rdata = prdata;
                break;
            end
            waits++;
            if (waits > 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL apb_timeout addr 0x%08h: pready 0 for %0d cycles, expected 1", addr, waits);
                break;
            end
        end
        @(posedge clk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        int          w;
        apb_xfer(1'b1, addr, data, rd, w);
    endtask

    task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int          w;
        apb_xfer(1'b0, addr, 32'h0, rd, w);
        check(name, rd, exp);
    endtask

    // Zero-time STAT sample inside a cycle; a STAT read has no side effects
    task automatic peek_stat(output logic [31:0] st);
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = A_STAT;
        #1;
        st      = prdata;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd, st;
        int           w;
        reg_vec_t     rv[15];
        cipher_vec_t  cv[8];

        rv[0]  = '{1'b1, A_KEY,        32'h12345678, 32'h0};
        rv[1]  = '{1'b0, A_KEY,        32'h0,        32'h12345678};
        rv[2]  = '{1'b0, 32'h00000108, 32'h0,        32'h12345678};
        rv[3]  = '{1'b1, A_CTRL,       32'h0000000F, 32'h0};
        rv[4]  = '{1'b0, A_CTRL,       32'h0,        32'h00000003};
        rv[5]  = '{1'b1, A_CTRL,       32'h0,        32'h0};
        rv[6]  = '{1'b0, A_CTRL,       32'h0,        32'h0};
        rv[7]  = '{1'b0, A_DIN,        32'h0,        32'h0};
        rv[8]  = '{1'b0, 32'h00000014, 32'h0,        32'h0};
        rv[9]  = '{1'b1, 32'h00000018, 32'hDEADBEEF, 32'h0};
        rv[10] = '{1'b0, 32'h0000001C, 32'h0,        32'h0};
        rv[11] = '{1'b1, A_DOUT,       32'h00000055, 32'h0};
        rv[12] = '{1'b0, A_STAT,       32'h0,        32'h0000000A};
        rv[13] = '{1'b1, A_KEY,        32'h0,        32'h0};
        rv[14] = '{1'b0, A_KEY,        32'h0,        32'h0};

        cv[0] = '{32'h1, 32'h00000000, 32'h00000001, 32'h00001000};
        cv[1] = '{32'h3, 32'h00000000, 32'h00001000, 32'h00000001};
        cv[2] = '{32'h1, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        cv[3] = '{32'h3, 32'hFFFFFFFF, 32'h00000000, 32'h00000000};
        cv[4] = '{32'h1, 32'h00000001, 32'h00000000, 32'h00001248};
        cv[5] = '{32'h3, 32'h00000001, 32'h00001248, 32'h00000000};
        cv[6] = '{32'h1, 32'h00000000, 32'h80000000, 32'h00000800};
        cv[7] = '{32'h3, 32'h00000000, 32'h00000800, 32'h80000000};

        // Reset state
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pready", 32'(pready), 32'h1);
        check("reset_prdata", prdata, 32'h0);
        peek_stat(st);
        check("reset_stat", st, 32'h0000000A);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Register map
        for (int i = 0; i < 15; i++) begin
            apb_xfer(rv[i].wr, rv[i].addr, rv[i].wdata, rd, w);
            check($sformatf("regvec%0d_waits", i), 32'(w), 32'h0);
            if (!rv[i].wr) check($sformatf("regvec%0d_rdata", i), rd, rv[i].exp);
        end

        // Latency: result lands in RX exactly ROUNDS+2 edges after the DIN commit
        wr(A_KEY, 32'h0);
        wr(A_CTRL, 32'h1);
        wr(A_DIN, 32'h1);
        for (int k = 1; k <= ROUNDS + 2; k++) begin
            @(posedge clk);
            #2;
            peek_stat(st);
            check($sformatf("latency_rx_count_edge%0d", k), 32'(st[19:16]), (k == ROUNDS + 2) ? 32'h1 : 32'h0);
            check($sformatf("latency_busy_edge%0d", k), 32'(st[4]), (k < ROUNDS + 2) ? 32'h1 : 32'h0);
        end
        read_check("latency_dout", A_DOUT, 32'h00001000);

        // Cipher vectors
        for (int i = 0; i < 8; i++) begin
            wr(A_KEY, cv[i].key);
            wr(A_CTRL, cv[i].ctrl);
            wr(A_DIN, cv[i].din);
            idle(ROUNDS + 4);
            apb_xfer(1'b0, A_DOUT, 32'h0, rd, w);
            check($sformatf("cipher%0d_dout", i), rd, cv[i].exp);
            check($sformatf("cipher%0d_waits", i), 32'(w), 32'h0);
        end

        // KEY written while busy applies only to the next word
        wr(A_KEY, 32'h0);
        wr(A_CTRL, 32'h1);
        wr(A_DIN, 32'h1);
        wr(A_KEY, 32'h1);
        idle(10);
        read_check("keychg_current_word", A_DOUT, 32'h00001000);
        wr(A_DIN, 32'h1);
        idle(10);
        read_check("keychg_next_word", A_DOUT, 32'h00000248);
        wr(A_KEY, 32'h0);

        // DOUT read stalls while the result is pending, then underflow
        wr(A_DIN, 32'h1);
        apb_xfer(1'b0, A_DOUT, 32'h0, rd, w);
        check("dout_wait_cycles", 32'(w), 32'd5);
        check("dout_wait_data", rd, 32'h00001000);
        apb_xfer(1'b0, A_DOUT, 32'h0, rd, w);
        check("udf_data", rd, 32'h0);
        check("udf_waits", 32'(w), 32'h0);
        peek_stat(st);
        check("udf_stat", st, 32'h0000004A);
        wr(A_CTRL, 32'h9);
        peek_stat(st);
        check("udf_cleared_stat", st, 32'h0000000A);

        // Overflow with engine disabled, then drain in order
        wr(A_CTRL, 32'h4);
        for (int i = 0; i < 5; i++) begin
            apb_xfer(1'b1, A_DIN, 32'(i + 1) << 4, rd, w);
            check($sformatf("ovf_din%0d_waits", i), 32'(w), 32'h0);
        end
        peek_stat(st);
        check("ovf_stat", st, 32'h00000429);
        wr(A_CTRL, 32'h9);
        peek_stat(st);
        check("ovf_cleared_stat", st, 32'h00000409);
        idle(40);
        peek_stat(st);
        check("ovf_drained_stat", st, 32'h00040006);
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("ovf_drain%0d", i), A_DOUT, 32'(i + 1) << 16);
        end
        peek_stat(st);
        check("ovf_empty_stat", st, 32'h0000000A);

        // DIN write into a full TX with engine enabled stalls until a pop
        for (int i = 0; i < 7; i++) begin
            apb_xfer(1'b1, A_DIN, 32'(i + 1), rd, w);
            check($sformatf("txwait_din%0d_waits", i), 32'(w), (i == 6) ? 32'd2 : 32'd0);
        end
        for (int i = 0; i < 7; i++) begin
            read_check($sformatf("txwait_dout%0d", i), A_DOUT, 32'(i + 1) << 12);
        end

        // Simultaneous TX push/pop and RX push/pop keep the counts
        wr(A_DIN, 32'hA);
        wr(A_DIN, 32'hB);
        idle(3);
        wr(A_DIN, 32'hC);
        peek_stat(st);
        check("sim_tx_pushpop_stat", st, 32'h00010110);
        idle(3);
        read_check("sim_rx_pushpop_data", A_DOUT, 32'h0000A000);
        peek_stat(st);
        check("sim_rx_pushpop_stat", st, 32'h00010100);
        idle(20);
        read_check("sim_dout_b", A_DOUT, 32'h0000B000);
        read_check("sim_dout_c", A_DOUT, 32'h0000C000);

        // RX full: engine holds in DONE until a DOUT pop
        for (int i = 0; i < 4; i++) wr(A_DIN, 32'(i + 1));
        idle(30);
        wr(A_DIN, 32'h5);
        idle(20);
        peek_stat(st);
        check("rxfull_hold_stat", st, 32'h00040016);
        read_check("rxfull_pop0", A_DOUT, 32'h00001000);
        peek_stat(st);
        check("rxfull_after_pop_stat", st, 32'h00030012);
        @(posedge clk);
        #2;
        peek_stat(st);
        check("rxfull_pushed_stat", st, 32'h00040006);
        for (int i = 1; i < 5; i++) begin
            read_check($sformatf("rxfull_pop%0d", i), A_DOUT, 32'(i + 1) << 12);
        end

        // fifo_clr while busy discards everything
        wr(A_DIN, 32'h11);
        wr(A_DIN, 32'h22);
        wr(A_CTRL, 32'h5);
        peek_stat(st);
        check("clr_stat", st, 32'h0000000A);
        idle(20);
        peek_stat(st);
        check("clr_later_stat", st, 32'h0000000A);
        wr(A_DIN, 32'h7);
        idle(10);
        read_check("clr_next_word", A_DOUT, 32'h00007000);

        // Reset pulse mid-RUN
        wr(A_KEY, 32'h5);
        wr(A_DIN, 32'h1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b0;
        paddr   = A_DOUT;
        #1;
        check("rst_run_pready", 32'(pready), 32'h1);
        check("rst_run_prdata", prdata, 32'h0);
        psel    = 1'b0;
        penable = 1'b0;
        peek_stat(st);
        check("rst_run_stat", st, 32'h0000000A);
        #1;
        rst = 1'b0;
        idle(12);
        peek_stat(st);
        check("rst_run_no_push_stat", st, 32'h0000000A);
        read_check("rst_run_ctrl", A_CTRL, 32'h0);
        read_check("rst_run_key", A_KEY, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
